// File: rtl/or_4bit_logic.sv
// or_4bit_logic: registered signed bitwise OR with sticky accumulate mode and zero/neg status flags
module or_4bit_logic #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    acc_mode,
  input  logic signed [WIDTH-1:0] in1,
  input  logic signed [WIDTH-1:0] in2,
  output logic signed [WIDTH-1:0] result,
  output logic                    out_valid,
  output logic                    zero,
  output logic                    neg
);
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                    valid_q, zero_q, neg_q;
  always_comb begin
    result_d = in_valid ? ((acc_mode ? result_q : '0) | in1 | in2) : result_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= in_valid;
      zero_q   <= ~|result_d;
      neg_q    <= result_d[WIDTH-1];
    end
  end
  assign result    = result_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
endmodule

// File: tb/tb_or_4bit_logic.sv
// tb_or_4bit_logic: table-driven directed vectors plus randomized checking against a behavioural model
module tb_or_4bit_logic;
  logic              clk = 1'b0;
  logic              rst = 1'b0, in_valid = 1'b0, acc_mode = 1'b0;
  logic signed [3:0] in1 = '0, in2 = '0;
  logic signed [3:0] result;
  logic              out_valid, zero, neg;
  int                checks = 0, errors = 0;
  logic signed [3:0] m_res = '0;
  logic              m_ov = 1'b0;

  or_4bit_logic #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .acc_mode(acc_mode),
    .in1(in1), .in2(in2), .result(result), .out_valid(out_valid),
    .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, v, a;
    logic [3:0] x, y, er;
    logic       eo, ez, en;
  } vec_t;

  vec_t tbl[20];

  task automatic apply(input logic r, v, a, input logic [3:0] x, y, output logic [6:0] got, output logic [6:0] mdl);
    @(negedge clk);
    rst = r; in_valid = v; acc_mode = a; in1 = x; in2 = y;
    @(posedge clk);
    if (r) begin
      m_res = '0;
      m_ov  = 1'b0;
    end else begin
      m_ov = v;
      if (v) m_res = (a ? m_res : 4'sd0) | $signed(x) | $signed(y);
    end
    #1;
    got = {result, out_valid, zero, neg};
    mdl = {m_res, m_ov, m_res == 0, m_res < 0};
  endtask

  task automatic check(input string name, input int idx, input logic [6:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got {result,ov,zero,neg}=%b, expected %b", name, idx, got, exp);
    end
  endtask

  initial begin
    logic [6:0] got, mdl;
    tbl = '{
      '{1,1,0,4'b1111,4'b0000, 4'b0000,0,1,0},
      '{1,1,0,4'b1111,4'b0000, 4'b0000,0,1,0},
      '{0,1,0,4'b0101,4'b1010, 4'b1111,1,0,1},
      '{0,0,0,4'b0000,4'b0000, 4'b1111,0,0,1},
      '{0,1,0,4'b1011,4'b0011, 4'b1011,1,0,1},
      '{0,1,0,4'b0000,4'b0000, 4'b0000,1,1,0},
      '{0,1,0,4'b1011,4'b0011, 4'b1011,1,0,1},
      '{0,1,0,4'b0000,4'b0000, 4'b0000,1,1,0},
      '{0,1,1,4'b0001,4'b0000, 4'b0001,1,0,0},
      '{0,1,1,4'b0000,4'b0100, 4'b0101,1,0,0},
      '{0,1,1,4'b0010,4'b0000, 4'b0111,1,0,0},
      '{0,1,0,4'b1000,4'b0000, 4'b1000,1,0,1},
      '{0,0,1,4'b0111,4'b0111, 4'b1000,0,0,1},
      '{0,1,1,4'b0000,4'b0000, 4'b1000,1,0,1},
      '{0,1,0,4'b0011,4'b0000, 4'b0011,1,0,0},
      '{1,1,0,4'b0101,4'b0000, 4'b0000,0,1,0},
      '{0,1,0,4'b0110,4'b0000, 4'b0110,1,0,0},
      '{0,1,1,4'b0001,4'b0000, 4'b0111,1,0,0},
      '{0,1,0,4'b1011,4'b0011, 4'b1011,1,0,1},
      '{0,0,0,4'b0000,4'b0000, 4'b1011,0,0,1}
    };
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].x, tbl[i].y, got, mdl);
      check("table", i, got, {tbl[i].er, tbl[i].eo, tbl[i].ez, tbl[i].en});
    end
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, i[0], 4'($urandom), 4'($urandom), got, mdl);
      check("hold", i, got, {4'b1011, 1'b0, 1'b0, 1'b1});
    end
    for (int i = 0; i < 300; i++) begin
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            4'($urandom), 4'($urandom), got, mdl);
      check("random", i, got, mdl);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
